// File: rtl/microondas_pkg.sv
// microondas_pkg: shared state encoding, power levels and preset program table for the cook sequencer
package microondas_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_ARM    = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_PAUSED = 3'd5;
  localparam logic [2:0] S_BEEP   = 3'd6;
  localparam logic [1:0] POT_BAIXA = 2'd0;
  localparam logic [1:0] POT_MEDIA = 2'd1;
  localparam logic [1:0] POT_ALTA  = 2'd2;
  // indexed [program][stage]; unused second stages of single-stage programs are zero
  localparam logic [1:0] NSTG  [4]    = '{2'd1, 2'd2, 2'd1, 2'd2};
  localparam logic [6:0] MIN_T [4][2] = '{'{7'd2, 7'd0}, '{7'd5, 7'd1}, '{7'd1, 7'd0}, '{7'd0, 7'd0}};
  localparam logic [6:0] SEC_T [4][2] = '{'{7'd30, 7'd0}, '{7'd0, 7'd0}, '{7'd30, 7'd0}, '{7'd20, 7'd10}};
  localparam logic [1:0] PWR_T [4][2] = '{'{POT_ALTA, POT_BAIXA}, '{POT_BAIXA, POT_MEDIA},
                                          '{POT_MEDIA, POT_BAIXA}, '{POT_BAIXA, POT_ALTA}};
  function automatic logic prog_last(input logic [1:0] p, input logic s);
    return {1'b0, s} == NSTG[p] - 2'd1;
  endfunction
endpackage

// File: rtl/program_rom.sv
// program_rom: combinational lookup of (program, stage) to timer value, power level and last-stage flag
module program_rom
  import microondas_pkg::*;
(
  input  logic [1:0] prog,
  input  logic       stage,
  output logic [6:0] rom_min,
  output logic [6:0] rom_sec,
  output logic [1:0] rom_pwr,
  output logic       rom_last
);
  assign rom_min  = MIN_T[prog][stage];
  assign rom_sec  = SEC_T[prog][stage];
  assign rom_pwr  = PWR_T[prog][stage];
  assign rom_last = prog_last(prog, stage);
endmodule

// File: rtl/cook_program_sequencer.sv
// cook_program_sequencer: steps the min/sec timer through preset multi-stage cooking programs
// Define DUTY_CYCLE_EN to gate heat_en by power level over a DUTY_PERIOD-cycle window while running.
module cook_program_sequencer
  import microondas_pkg::*;
#(
  parameter int BEEP_CYCLES = 8,
  parameter int DUTY_PERIOD = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       stop_p,
  input  logic       porta,
  input  logic [1:0] prog_sel,
  input  logic       tmr_done,
  output logic [6:0] tmr_min,
  output logic [6:0] tmr_sec,
  output logic       tmr_load,
  output logic       tmr_start,
  output logic       tmr_pause,
  output logic       tmr_stop,
  output logic [1:0] power_lvl,
  output logic       heat_en,
  output logic       stage_o,
  output logic [2:0] state_o,
  output logic       busy,
  output logic       beep
);
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic [2:0] state, nxt;
  logic [1:0] prog;
  logic stage;
  logic [BW-1:0] bcnt;
  logic [6:0] r_min, r_sec;
  logic [1:0] r_pwr;
  logic r_last, heat_nxt;
  if (DUTY_PERIOD < 4) begin : g_bad_duty
    $error("DUTY_PERIOD must be at least 4");
  end
  program_rom u_rom (
    .prog(prog), .stage(stage), .rom_min(r_min), .rom_sec(r_sec), .rom_pwr(r_pwr), .rom_last(r_last)
  );
  // RUN events resolve as stop > door open > pause > timer done
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = (start_p && !porta) ? S_LOAD : S_IDLE;
      S_LOAD:   nxt = S_START;
      S_START:  nxt = S_ARM;
      S_ARM:    nxt = tmr_done ? S_ARM : S_RUN;
      S_RUN:    nxt = stop_p ? S_IDLE : (porta || pause_p) ? S_PAUSED :
                      !tmr_done ? S_RUN : r_last ? S_BEEP : S_LOAD;
      S_PAUSED: nxt = stop_p ? S_IDLE : ((start_p || pause_p) && !porta) ? S_ARM : S_PAUSED;
      S_BEEP:   nxt = (stop_p || bcnt == BW'(BEEP_CYCLES - 1)) ? S_IDLE : S_BEEP;
      default:  nxt = S_IDLE;
    endcase
  end
`ifdef DUTY_CYCLE_EN
  localparam int DW = $clog2(DUTY_PERIOD);
  logic [DW-1:0] dcnt, dnxt;
  always_comb dnxt = (state != S_RUN || dcnt == DW'(DUTY_PERIOD - 1)) ? '0 : dcnt + 1'b1;
  always_comb heat_nxt = nxt == S_RUN && (power_lvl == POT_ALTA ||
                         dnxt < (power_lvl == POT_MEDIA ? DW'(DUTY_PERIOD / 2) : DW'(DUTY_PERIOD / 4)));
  always_ff @(posedge clock) dcnt <= reset ? '0 : dnxt;
`else
  always_comb heat_nxt = nxt == S_RUN;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      prog      <= '0;
      stage     <= 1'b0;
      bcnt      <= '0;
      tmr_min   <= '0;
      tmr_sec   <= '0;
      power_lvl <= '0;
      tmr_load  <= 1'b0;
      tmr_start <= 1'b0;
      tmr_pause <= 1'b0;
      tmr_stop  <= 1'b0;
      heat_en   <= 1'b0;
      busy      <= 1'b0;
      beep      <= 1'b0;
    end else begin
      state     <= nxt;
      tmr_load  <= state == S_LOAD;
      tmr_start <= state == S_START || (state == S_PAUSED && nxt == S_ARM);
      tmr_pause <= state == S_RUN && nxt == S_PAUSED;
      tmr_stop  <= (state == S_RUN || state == S_PAUSED) && stop_p;
      heat_en   <= heat_nxt;
      busy      <= nxt != S_IDLE;
      beep      <= nxt == S_BEEP;
      bcnt      <= state == S_BEEP ? bcnt + 1'b1 : '0;
      if (state == S_IDLE && nxt == S_LOAD) begin
        prog  <= prog_sel;
        stage <= 1'b0;
      end
      if (state == S_RUN && nxt == S_LOAD) stage <= stage + 1'b1;
      if (state == S_LOAD) begin
        tmr_min   <= r_min;
        tmr_sec   <= r_sec;
        power_lvl <= r_pwr;
      end
    end
  end
  assign state_o = state;
  assign stage_o = stage;
endmodule

// File: tb/tb_cook_program_sequencer.sv
// tb_cook_program_sequencer: directed self-checking bench for the cook program sequencer
module tb_cook_program_sequencer;
  logic clock = 0, reset = 1, start_p = 0, pause_p = 0, stop_p = 0, porta = 0, tmr_done = 0;
  logic [1:0] prog_sel = 0;
  logic [6:0] tmr_min, tmr_sec;
  logic tmr_load, tmr_start, tmr_pause, tmr_stop, heat_en, stage_o, busy, beep;
  logic [1:0] power_lvl;
  logic [2:0] state_o;
  int total = 0, passed = 0, cnt;
  cook_program_sequencer dut (
    .clock(clock), .reset(reset), .start_p(start_p), .pause_p(pause_p), .stop_p(stop_p),
    .porta(porta), .prog_sel(prog_sel), .tmr_done(tmr_done), .tmr_min(tmr_min), .tmr_sec(tmr_sec),
    .tmr_load(tmr_load), .tmr_start(tmr_start), .tmr_pause(tmr_pause), .tmr_stop(tmr_stop),
    .power_lvl(power_lvl), .heat_en(heat_en), .stage_o(stage_o), .state_o(state_o),
    .busy(busy), .beep(beep)
  );
  always #5 clock = ~clock;
  wire [26:0] outs = {tmr_min, tmr_sec, tmr_load, tmr_start, tmr_pause, tmr_stop, power_lvl,
                      heat_en, stage_o, state_o, busy, beep};
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  initial begin
    tick(); tick();
    chk("reset_outs", 32'(outs), 0);
    reset = 0;
    // popcorn: 02:30 high, single stage
    prog_sel = 0; start_p = 1; tick(); start_p = 0;
    chk("p0_load_state", 32'(state_o), 1);
    chk("p0_busy", 32'(busy), 1);
    tick();
    chk("p0_load_strobe", 32'({tmr_load, tmr_start}), 2);
    chk("p0_min_sec_pwr", 32'({tmr_min, tmr_sec, power_lvl}), 32'({7'd2, 7'd30, 2'd2}));
    tick();
    chk("p0_start_strobe", 32'({tmr_load, tmr_start, state_o}), 32'({1'b0, 1'b1, 3'd3}));
    tick();
    chk("p0_run", 32'({state_o, heat_en, tmr_start}), 32'({3'd4, 1'b1, 1'b0}));
    tmr_done = 1; tick();
    chk("p0_beep_entry", 32'({state_o, beep, heat_en}), 32'({3'd6, 1'b1, 1'b0}));
    cnt = 1;
    for (int i = 1; i < 8; i++) begin
      start_p = (i == 3);
      tick();
      cnt += beep;
    end
    start_p = 0;
    chk("p0_beep_len", cnt, 8);
    tick();
    chk("p0_idle_after_beep", 32'({state_o, busy, beep}), 0);
    chk("p0_hold_values", 32'({tmr_min, tmr_sec, power_lvl}), 32'({7'd2, 7'd30, 2'd2}));
    tmr_done = 0;
    // defrost: 05:00 low then 01:00 medium; prog_sel change mid-run is ignored
    prog_sel = 1; start_p = 1; tick(); start_p = 0; prog_sel = 3;
    tick();
    chk("p1_s0_load", 32'({tmr_load, tmr_min, tmr_sec, power_lvl}), 32'({1'b1, 7'd5, 7'd0, 2'd0}));
    tick(); tick();
    chk("p1_s0_run", 32'(state_o), 4);
    tmr_done = 1; tick(); tmr_done = 0;
    chk("p1_advance", 32'({state_o, stage_o, heat_en}), 32'({3'd1, 1'b1, 1'b0}));
    tick();
    chk("p1_s1_load", 32'({tmr_load, tmr_min, tmr_sec, power_lvl, stage_o}),
        32'({1'b1, 7'd1, 7'd0, 2'd1, 1'b1}));
    tick(); tick();
    tmr_done = 1; tick(); tmr_done = 0;
    chk("p1_beep", 32'({state_o, beep}), 32'({3'd6, 1'b1}));
    stop_p = 1; tick(); stop_p = 0;
    chk("p1_beep_stop", 32'({state_o, beep, tmr_stop, busy}), 0);
    // reheat: door open pauses, resume ignored until door closes
    prog_sel = 2; start_p = 1; tick(); start_p = 0;
    tick(); tick(); tick();
    chk("p2_run", 32'({state_o, heat_en}), 32'({3'd4, 1'b1}));
    porta = 1; tick();
    chk("p2_door_pause", 32'({state_o, tmr_pause, heat_en}), 32'({3'd5, 1'b1, 1'b0}));
    tick(); start_p = 1; tick(); start_p = 0;
    chk("p2_resume_door_open", 32'({state_o, tmr_start, tmr_pause}), 32'({3'd5, 1'b0, 1'b0}));
    porta = 0; tick();
    start_p = 1; tick(); start_p = 0;
    chk("p2_resume", 32'({state_o, tmr_start}), 32'({3'd3, 1'b1}));
    tick();
    chk("p2_rerun", 32'({state_o, heat_en, tmr_start}), 32'({3'd4, 1'b1, 1'b0}));
    pause_p = 1; tick();
    chk("p2_pause_btn", 32'({state_o, tmr_pause}), 32'({3'd5, 1'b1}));
    tick(); pause_p = 0;
    chk("p2_pause_resume", 32'({state_o, tmr_start, tmr_pause}), 32'({3'd3, 1'b1, 1'b0}));
    tick();
    stop_p = 1; tmr_done = 1; tick(); stop_p = 0; tmr_done = 0;
    chk("p2_stop_wins", 32'({state_o, tmr_stop, beep, busy}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));
    tick();
    chk("p2_stop_one_cycle", 32'(tmr_stop), 0);
    // door open blocks start in IDLE
    porta = 1; start_p = 1; tick(); start_p = 0; porta = 0;
    chk("idle_door_start", 32'({state_o, busy, tmr_load, tmr_start}), 0);
    tick();
    chk("idle_door_start_late", 32'({state_o, tmr_load}), 0);
    // soften: 00:20 low, then 00:10 high; reset mid-run
    prog_sel = 3; start_p = 1; tick(); start_p = 0;
    tick();
    chk("p3_s0_load", 32'({tmr_min, tmr_sec, power_lvl}), 32'({7'd0, 7'd20, 2'd0}));
    tick(); tick();
    cnt = heat_en;
    for (int i = 1; i < 16; i++) begin
      tick();
      cnt += heat_en;
    end
`ifdef DUTY_CYCLE_EN
    chk("p3_low_duty", cnt, 4);
`else
    chk("p3_low_duty", cnt, 16);
`endif
    tmr_done = 1; tick(); tmr_done = 0;
    tick();
    chk("p3_s1_load", 32'({tmr_min, tmr_sec, power_lvl, stage_o}), 32'({7'd0, 7'd10, 2'd2, 1'b1}));
    tick(); tick(); tick();
    chk("p3_s1_run", 32'({state_o, stage_o, heat_en}), 32'({3'd4, 1'b1, 1'b1}));
    reset = 1; tick(); reset = 0;
    chk("p3_reset_abort", 32'(outs), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
